// File: rtl/ascii_ps2_tx.sv
// rtl/ascii_ps2_tx.sv - ASCII to PS/2 set-2 keystroke transmitter (make, F0, make)
module ascii_ps2_tx #(
    parameter int HALF_PER = 4000,
    parameter int GAP_CYC  = 8000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ascii_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    // One timing counter serves both the half-bit phases and the inter-frame gap.
    localparam int CNT_MAX = (HALF_PER > GAP_CYC) ? HALF_PER : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PER - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);
    localparam logic [3:0]    LAST_BIT  = 4'd10;
    localparam logic [1:0]    LAST_BYTE = 2'd2;
    localparam logic [7:0]    BREAK_CODE = 8'hF0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIT_HI = 3'd1,
        BIT_LO = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [3:0]      bit_idx;
    logic [3:0]      bit_nxt;
    logic [1:0]      byte_idx;
    logic [1:0]      byte_nxt;
    logic [7:0]      code;
    logic            err_q;

    logic [7:0]      folded;
    logic [7:0]      lut_code;
    logic            lut_hit;
    logic            accept;
    logic [7:0]      cur_byte;
    logic [10:0]     frame;

    assign accept   = valid_i && (state == IDLE);
    assign cur_byte = (byte_idx == 2'd1) ? BREAK_CODE : code;
    assign frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};

    // Fold lowercase letters onto uppercase, then map to the set-2 make code.
    always_comb begin
        folded   = ascii_i;
        lut_code = 8'h00;
        lut_hit  = 1'b1;
        if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) begin
            folded = ascii_i - 8'h20;
        end
        case (folded)
            8'h0D: lut_code = 8'h5A;
            8'h20: lut_code = 8'h29;
            8'h1B: lut_code = 8'h76;
            8'h05: lut_code = 8'h05;
            8'h06: lut_code = 8'h06;
            8'h04: lut_code = 8'h04;
            8'h2B: lut_code = 8'h79;
            8'h2D: lut_code = 8'h7B;
            8'h2A: lut_code = 8'h7C;
            8'h30: lut_code = 8'h70;
            8'h31: lut_code = 8'h69;
            8'h32: lut_code = 8'h72;
            8'h33: lut_code = 8'h7A;
            8'h34: lut_code = 8'h6B;
            8'h35: lut_code = 8'h73;
            8'h36: lut_code = 8'h74;
            8'h37: lut_code = 8'h6C;
            8'h38: lut_code = 8'h75;
            8'h39: lut_code = 8'h7D;
            8'h41: lut_code = 8'h1C;
            8'h42: lut_code = 8'h32;
            8'h43: lut_code = 8'h21;
            8'h44: lut_code = 8'h23;
            8'h45: lut_code = 8'h24;
            8'h46: lut_code = 8'h2B;
            8'h47: lut_code = 8'h34;
            8'h48: lut_code = 8'h33;
            8'h49: lut_code = 8'h43;
            8'h4A: lut_code = 8'h3B;
            8'h4B: lut_code = 8'h42;
            8'h4C: lut_code = 8'h4B;
            8'h4D: lut_code = 8'h3A;
            8'h4E: lut_code = 8'h31;
            8'h4F: lut_code = 8'h44;
            8'h50: lut_code = 8'h4D;
            8'h51: lut_code = 8'h15;
            8'h52: lut_code = 8'h2D;
            8'h53: lut_code = 8'h1B;
            8'h54: lut_code = 8'h2C;
            8'h55: lut_code = 8'h3C;
            8'h56: lut_code = 8'h2A;
            8'h57: lut_code = 8'h1D;
            8'h58: lut_code = 8'h22;
            8'h59: lut_code = 8'h35;
            8'h5A: lut_code = 8'h1A;
            default: lut_hit = 1'b0;
        endcase
    end

    // State, counters, latched make code and the reject pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
            code     <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            if (accept && lut_hit) begin
                code <= lut_code;
            end
            err_q <= accept && !lut_hit;
        end
    end

    // Sequence bit phases, inter-frame gaps and the three bytes of a keystroke.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        case (state)
            IDLE: begin
                if (valid_i && lut_hit) begin
                    state_nxt = BIT_HI;
                    cnt_nxt   = HALF_LOAD;
                    bit_nxt   = 4'd0;
                    byte_nxt  = 2'd0;
                end
            end
            BIT_HI: begin
                if (cnt == '0) begin
                    state_nxt = BIT_LO;
                    cnt_nxt   = HALF_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            BIT_LO: begin
                if (cnt == '0) begin
                    if (bit_idx == LAST_BIT) begin
                        if (byte_idx < LAST_BYTE) begin
                            state_nxt = GAP;
                            cnt_nxt   = GAP_LOAD;
                        end else begin
                            state_nxt = FINISH;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        state_nxt = BIT_HI;
                        cnt_nxt   = HALF_LOAD;
                        bit_nxt   = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = BIT_HI;
                    cnt_nxt   = HALF_LOAD;
                    bit_nxt   = 4'd0;
                    byte_nxt  = byte_idx + 2'd1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                bit_nxt   = 4'd0;
                byte_nxt  = 2'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                bit_nxt   = 4'd0;
                byte_nxt  = 2'd0;
            end
        endcase
    end

    // Line levels and status decoded from the current state; data holds for the whole bit.
    always_comb begin
        ready_o    = (state == IDLE);
        busy_o     = (state != IDLE);
        done_o     = (state == FINISH);
        err_o      = err_q;
        ps2_clk_o  = (state != BIT_LO);
        ps2_data_o = 1'b1;
        if (state == BIT_HI || state == BIT_LO) begin
            ps2_data_o = frame[bit_idx];
        end
    end

endmodule
